jk_drv_seq: RTL

JK_DRV_SEQ -- requirements
Module: jk_drv_seq

---
 rtl/jk_drv_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/jk_drv_seq.sv
// jk_drv_seq: drives a downstream JK flip-flop stage through the four JK
// operations HOLD -> CLR -> SET -> TOG. Each phase lasts max(dwell,1) cycles.
// An internal model bit qm tracks what the JK stage should hold, and q0
// presents it as the stage's present-state input.
// Optional compare logic (macro JK_DRV_SEQ_CHECK_EN) checks the stage's q1
// against qm one cycle after each drive cycle. It keeps a sticky err flag
// and a saturating err_cnt.
module jk_drv_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dwell,
  input  logic       q1,
  output logic       j,
  output logic       k,
  output logic       q0,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_CLR  = 3'd2,
    S_SET  = 3'd3,
    S_TOG  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t     state_q;
  logic [7:0] cnt_q;     // cycles left in the current phase, minus one
  logic [7:0] dwm1_q;    // max(dwell,1)-1, latched when start is accepted
  logic       qm_q;      // model of the JK stage state
  logic       chk_q;     // previous cycle was a drive cycle
  logic       j_q, k_q, busy_q, done_q;

  logic       drive;
  logic       qm_d;
  logic [7:0] dwm1_d;

  assign drive  = (state_q == S_HOLD) || (state_q == S_CLR) ||
                  (state_q == S_SET)  || (state_q == S_TOG);
  // A dwell of 0 runs like a dwell of 1.
  assign dwm1_d = (dwell == 8'd0) ? 8'd0 : dwell - 8'd1;

  // Next value of the model bit: the JK function for the current phase.
  always_comb begin
    qm_d = qm_q;
    case (state_q)
      S_CLR:   qm_d = 1'b0;
      S_SET:   qm_d = 1'b1;
      S_TOG:   qm_d = ~qm_q;
      default: qm_d = qm_q;
    endcase
  end

  // Phase sequencer. Outputs are registered for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      dwm1_q  <= 8'd0;
      qm_q    <= 1'b0;
      chk_q   <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      chk_q <= drive;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_HOLD;
            dwm1_q  <= dwm1_d;
            cnt_q   <= dwm1_d;
            qm_q    <= 1'b0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_HOLD, S_CLR, S_SET, S_TOG: begin
          qm_q <= qm_d;
          if (cnt_q == 8'd0) begin
            cnt_q <= dwm1_q;
            case (state_q)
              S_HOLD: begin
                state_q <= S_CLR;
                j_q     <= 1'b0;
                k_q     <= 1'b1;
              end
              S_CLR: begin
                state_q <= S_SET;
                j_q     <= 1'b1;
                k_q     <= 1'b0;
              end
              S_SET: begin
                state_q <= S_TOG;
                j_q     <= 1'b1;
                k_q     <= 1'b1;
              end
              default: begin
                state_q <= S_DONE;
                j_q     <= 1'b0;
                k_q     <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            endcase
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          j_q     <= 1'b0;
          k_q     <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign j    = j_q;
  assign k    = k_q;
  assign q0   = qm_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef JK_DRV_SEQ_CHECK_EN
  logic       err_q;
  logic [7:0] err_cnt_q;

  // Compare the stage's q1 with qm one cycle after each drive cycle.
  // The flag is sticky and the count saturates. Both clear on start accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else if ((state_q == S_IDLE) && start) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else if (chk_q && (q1 != qm_q)) begin
      err_q <= 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`else
  // No compare logic in this build, so q1 and the check-valid flag go unobserved.
  logic unused_nochk;
  assign unused_nochk = q1 ^ chk_q;
  assign err          = 1'b0;
  assign err_cnt      = 8'd0;
`endif

endmodule
